// File: rtl/trigger_clk_phase_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trigger_clk_phase_ctrl : steps the trigger-clock MMCM phase toward a target
// Revision: 1.0
// ---------------------------------------------------------------------------
module trigger_clk_phase_ctrl #(
  parameter int pSTEP_WIDTH = 16,
  parameter int pTIMEOUT    = 255
) (
  input  logic                   usb_clk,
  input  logic                   reset_n,
  input  logic [pSTEP_WIDTH-1:0] I_target_phase,
  input  logic                   I_go,
  input  logic                   I_abort,
  input  logic                   I_clear_error,
  input  logic                   trigger_clk_locked,
  input  logic                   trigger_clk_psdone,
  output logic                   O_psen,
  output logic                   O_psincdec,
  output logic [pSTEP_WIDTH-1:0] O_current_phase,
  output logic                   O_busy,
  output logic                   O_done,
  output logic                   O_error,
  output logic [1:0]             O_error_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [15:0] TIMEOUT_LOAD = 16'(pTIMEOUT);

  localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
  localparam logic [1:0] ERR_LOCK_LOST = 2'd2;
  localparam logic [1:0] ERR_UNLOCKED  = 2'd3;

  logic [2:0]                    state;
  logic                          lock_meta;
  logic                          locked_s;
  logic signed [pSTEP_WIDTH-1:0] current;
  logic signed [pSTEP_WIDTH-1:0] target;
  logic [15:0]                   timeout_cnt;
  logic                          abort_pending;
  logic                          psincdec;
  logic                          done;
  logic                          error;
  logic [1:0]                    error_code;
  logic                          busy;

  assign busy = (state == S_CHECK) || (state == S_STEP) || (state == S_WAIT);

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      lock_meta     <= 1'b0;
      locked_s      <= 1'b0;
      current       <= '0;
      target        <= '0;
      timeout_cnt   <= '0;
      abort_pending <= 1'b0;
      psincdec      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      error_code    <= 2'd0;
    end else begin
      lock_meta <= trigger_clk_locked;
      locked_s  <= lock_meta;
      done      <= 1'b0;

      // An MMCM that dropped lock has been reset, so its phase is back at 0.
      if (!locked_s) begin
        current <= '0;
      end

      case (state)
        S_IDLE: begin
          abort_pending <= 1'b0;
          if (I_go) begin
            if (locked_s) begin
              target <= I_target_phase;
              state  <= S_CHECK;
            end else begin
              error      <= 1'b1;
              error_code <= ERR_UNLOCKED;
              state      <= S_ERROR;
            end
          end
        end

        S_CHECK: begin
          if (!locked_s) begin
            error      <= 1'b1;
            error_code <= ERR_LOCK_LOST;
            state      <= S_ERROR;
          end else if ((current == target) || abort_pending) begin
            done          <= (current == target) && !abort_pending;
            abort_pending <= 1'b0;
            state         <= S_IDLE;
          end else begin
            psincdec <= (target > current);
            state    <= S_STEP;
          end
        end

        S_STEP: begin
          if (!locked_s) begin
            error      <= 1'b1;
            error_code <= ERR_LOCK_LOST;
            state      <= S_ERROR;
          end else begin
            timeout_cnt <= TIMEOUT_LOAD;
            state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!locked_s) begin
            error      <= 1'b1;
            error_code <= ERR_LOCK_LOST;
            state      <= S_ERROR;
          end else if (trigger_clk_psdone) begin
            current <= psincdec ? current + 1'b1 : current - 1'b1;
            state   <= S_CHECK;
          end else if (timeout_cnt <= 16'd1) begin
            // The final decrement to zero is the timeout: exactly pTIMEOUT wait cycles.
            error      <= 1'b1;
            error_code <= ERR_TIMEOUT;
            state      <= S_ERROR;
          end else begin
            timeout_cnt <= timeout_cnt - 16'd1;
          end
        end

        S_ERROR: begin
          abort_pending <= 1'b0;
          if (I_clear_error) begin
            error      <= 1'b0;
            error_code <= 2'd0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Late assignment so an abort arriving in any busy cycle is never lost.
      if (I_abort && busy && (state != S_CHECK || (locked_s && current != target && !abort_pending))) begin
        abort_pending <= 1'b1;
      end
    end
  end

  assign O_psen          = (state == S_STEP);
  assign O_psincdec      = psincdec;
  assign O_current_phase = current;
  assign O_busy          = busy;
  assign O_done          = done;
  assign O_error         = error;
  assign O_error_code    = error_code;

endmodule
`default_nettype wire

// File: tb/tb_trigger_clk_phase_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trigger_clk_phase_ctrl : scoreboard bench with an MMCM psdone responder
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_trigger_clk_phase_ctrl;

  localparam int W   = 16;
  localparam int TMO = 10;

  logic                 usb_clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [W-1:0]         I_target_phase = '0;
  logic                 I_go = 1'b0;
  logic                 I_abort = 1'b0;
  logic                 I_clear_error = 1'b0;
  logic                 trigger_clk_locked = 1'b1;
  logic                 trigger_clk_psdone = 1'b0;
  logic                 O_psen;
  logic                 O_psincdec;
  logic [W-1:0]         O_current_phase;
  logic                 O_busy;
  logic                 O_done;
  logic                 O_error;
  logic [1:0]           O_error_code;

  trigger_clk_phase_ctrl #(.pSTEP_WIDTH(W), .pTIMEOUT(TMO)) dut (
    .usb_clk            (usb_clk),
    .reset_n            (reset_n),
    .I_target_phase     (I_target_phase),
    .I_go               (I_go),
    .I_abort            (I_abort),
    .I_clear_error      (I_clear_error),
    .trigger_clk_locked (trigger_clk_locked),
    .trigger_clk_psdone (trigger_clk_psdone),
    .O_psen             (O_psen),
    .O_psincdec         (O_psincdec),
    .O_current_phase    (O_current_phase),
    .O_busy             (O_busy),
    .O_done             (O_done),
    .O_error            (O_error),
    .O_error_code       (O_error_code)
  );

  always #5 usb_clk = ~usb_clk;

  // kind: 0 = done pulse, 1 = error raised, 2 = quiet stop (abort), 3 = error cleared
  typedef struct {
    int kind;
    int code;
    int phase;
    int ups;
    int downs;
    int gap_go;
    int gap_psen;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   go_cyc = 0;
  int   psen_cyc = -100;
  int   mon_ups = 0;
  int   mon_downs = 0;
  bit   withhold = 1'b0;
  int   model_phase = 0;

  always @(posedge usb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int code, input int phase,
                               input int ups, input int downs, input int gap_go, input int gap_psen);
    exp_t e;
    e.kind = kind; e.code = code; e.phase = phase; e.ups = ups; e.downs = downs;
    e.gap_go = gap_go; e.gap_psen = gap_psen;
    sb.push_back(e);
  endfunction

  // MMCM stand-in: acknowledges each psen after a random delay unless withheld.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge usb_clk);
      trigger_clk_psdone = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) trigger_clk_psdone = 1'b1;
      end
      if (reset_n && O_psen) begin
        check("psen_while_outstanding", cnt, 0);
        total++;
        if (cyc - psen_cyc < 3) begin
          bad++;
          $display("FAIL psen_spacing: got %0d cycles required >= 3", cyc - psen_cyc);
        end
        psen_cyc = cyc;
        if (!withhold) cnt = int'($urandom_range(1, 6));
      end
    end
  end

  // Monitor: turns output activity into events and checks them against the scoreboard.
  initial begin
    bit   pb, pe;
    int   kind;
    exp_t e;
    pb = 1'b0; pe = 1'b0;
    forever begin
      @(negedge usb_clk);
      if (O_psen) begin
        if (O_psincdec) mon_ups++;
        else mon_downs++;
      end
      kind = -1;
      if (O_done) kind = 0;
      else if (O_error && !pe) kind = 1;
      else if (!O_error && pe) kind = 3;
      else if (pb && !O_busy) kind = 2;
      if (kind >= 0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got kind %0d required none (cycle %0d)", kind, cyc);
        end else begin
          e = sb.pop_front();
          check("event_kind", kind, e.kind);
          check("error_code", int'(O_error_code), e.code);
          check("phase", int'($signed(O_current_phase)), e.phase);
          check("inc_steps", mon_ups, e.ups);
          check("dec_steps", mon_downs, e.downs);
          check("busy_at_end", int'(O_busy), 0);
          if (e.gap_go >= 0) check("go_to_done_cycles", cyc - go_cyc, e.gap_go);
          if (e.gap_psen >= 0) check("psen_to_error_cycles", cyc - psen_cyc, e.gap_psen);
        end
        mon_ups = 0;
        mon_downs = 0;
      end
      pb = O_busy;
      pe = O_error;
    end
  end

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge usb_clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending events required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge usb_clk);
  endtask

  task automatic wait_ups(input int want);
    int n;
    n = 0;
    while (mon_ups < want && n < 500) begin
      @(negedge usb_clk);
      n++;
    end
    if (mon_ups < want) begin
      total++;
      bad++;
      $display("FAIL step_wait: got %0d steps required %0d", mon_ups, want);
    end
  endtask

  task automatic go(input int tgt);
    @(negedge usb_clk);
    I_target_phase = W'(tgt);
    I_go = 1'b1;
    go_cyc = cyc;
    @(negedge usb_clk);
    I_go = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge usb_clk);
    I_clear_error = 1'b1;
    @(negedge usb_clk);
    I_clear_error = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge usb_clk);
    I_abort = 1'b1;
    @(negedge usb_clk);
    I_abort = 1'b0;
  endtask

  task automatic run_to(input int tgt);
    int diff;
    diff = tgt - model_phase;
    push(0, 0, tgt, (diff > 0) ? diff : 0, (diff < 0) ? -diff : 0, (diff == 0) ? 2 : -1, -1);
    go(tgt);
    model_phase = tgt;
    wait_drain(3000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge usb_clk);
    check("reset_psen", int'(O_psen), 0);
    check("reset_psincdec", int'(O_psincdec), 0);
    check("reset_phase", int'(O_current_phase), 0);
    check("reset_busy", int'(O_busy), 0);
    check("reset_done", int'(O_done), 0);
    check("reset_error", int'(O_error), 0);
    check("reset_error_code", int'(O_error_code), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge usb_clk);

    run_to(5);
    run_to(5);
    run_to(-3);

    // psdone withheld: timeout after TMO wait cycles, phase unchanged
    withhold = 1'b1;
    push(1, 1, model_phase, 0, 1, -1, TMO + 1);
    go(model_phase - 1);
    wait_drain(200);
    push(3, 0, model_phase, 0, 0, -1, -1);
    pulse_clear();
    wait_drain(50);
    withhold = 1'b0;

    // abort during the second step of a +10 move
    push(2, 0, model_phase + 2, 2, 0, -1, -1);
    go(model_phase + 10);
    wait_ups(2);
    pulse_abort();
    wait_drain(200);
    model_phase = model_phase + 2;

    // lock lost mid-WAIT
    withhold = 1'b1;
    push(1, 2, 0, 1, 0, -1, -1);
    go(model_phase + 5);
    wait_ups(1);
    @(negedge usb_clk);
    trigger_clk_locked = 1'b0;
    wait_drain(200);
    model_phase = 0;
    go(3);
    repeat (10) @(negedge usb_clk);
    push(3, 0, 0, 0, 0, -1, -1);
    pulse_clear();
    wait_drain(50);
    push(1, 3, 0, 0, 0, -1, -1);
    go(7);
    wait_drain(50);
    trigger_clk_locked = 1'b1;
    repeat (5) @(negedge usb_clk);
    push(3, 0, 0, 0, 0, -1, -1);
    pulse_clear();
    wait_drain(50);
    withhold = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_to(int'($urandom_range(0, 60)) - 30);
    end

    repeat (5) @(negedge usb_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
